// File: rtl/neuron_cfg_driver_if.sv
// neuron_cfg_driver_if: host request/status and neuron setting-bus signals (master = driver, slave = host/neuron side)
interface neuron_cfg_driver_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              abort;
  logic [DATA_W-1:0] beta_in;
  logic [DATA_W-1:0] thresh_in;
  logic [LEN_W-1:0]  read_len;
  logic              spike_in;
  logic [6:0]        setting;
  logic [DATA_W-1:0] cfg_data;
  logic [1:0]        peer_state;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [CNT_W-1:0]  spike_count;
  modport master (
    input  start, abort, beta_in, thresh_in, read_len, spike_in,
    output setting, cfg_data, peer_state, busy, done, aborted, spike_count
  );
  modport slave (
    output start, abort, beta_in, thresh_in, read_len, spike_in,
    input  setting, cfg_data, peer_state, busy, done, aborted, spike_count
  );
endinterface

// File: rtl/neuron_cfg_driver.sv
// neuron_cfg_driver: walks the neuron config FSM IDLE->BETA->THRESH->READ->IDLE, presents beta/threshold, counts READ-window spikes (ports: clk, rst_n sync active-low, bus master modport)
module neuron_cfg_driver #(
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int LEN_W       = 8,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  neuron_cfg_driver_if.master    bus
);
  typedef enum logic [2:0] {D_IDLE, D_BETA, D_THRESH, D_READ, D_RET} state_t;
  localparam int CW = (LEN_W > $clog2(HOLD_CYCLES) + 1) ? LEN_W : $clog2(HOLD_CYCLES) + 1;
  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_CYCLES - 1);
  state_t            st_q;
  logic [CW-1:0]     cnt_q;
  logic [6:0]        setting_q;
  logic [1:0]        peer_q, peer_d;
  logic [DATA_W-1:0] beta_q, thr_q;
  logic [LEN_W-1:0]  len_m1_q;
  logic              busy_q, done_q, aborted_q, ab_q, last;
  logic [CNT_W-1:0]  spk_q;
  always_comb begin
    // the receiver only advances on the next code in its cycle, otherwise holds
    peer_d = (setting_q == {5'd0, peer_q + 2'd1}) ? setting_q[1:0] : peer_q;
    // a pending or sticky abort collapses every remaining phase to one cycle
    last   = (cnt_q == '0) || ab_q || bus.abort;
  end
  assign bus.setting     = setting_q;
  assign bus.peer_state  = peer_q;
  assign bus.cfg_data    = (peer_q == 2'd1) ? beta_q : (peer_q == 2'd2) ? thr_q : '0;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;
  assign bus.spike_count = spk_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q      <= D_IDLE;
      cnt_q     <= '0;
      setting_q <= '0;
      peer_q    <= '0;
      beta_q    <= '0;
      thr_q     <= '0;
      len_m1_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      ab_q      <= 1'b0;
      spk_q     <= '0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      peer_q    <= peer_d;
      if (peer_q == 2'd3 && bus.spike_in && !(&spk_q)) spk_q <= spk_q + CNT_W'(1);
      case (st_q)
        D_IDLE: if (bus.start) begin
          beta_q    <= bus.beta_in;
          thr_q     <= bus.thresh_in;
          len_m1_q  <= (bus.read_len == '0) ? '0 : bus.read_len - LEN_W'(1);
          spk_q     <= '0;
          ab_q      <= 1'b0;
          cnt_q     <= HOLD_M1;
          st_q      <= D_BETA;
          setting_q <= 7'd1;
          busy_q    <= 1'b1;
        end
        D_BETA: begin
          if (bus.abort) ab_q <= 1'b1;
          if (last) begin
            cnt_q     <= HOLD_M1;
            st_q      <= D_THRESH;
            setting_q <= 7'd2;
          end else cnt_q <= cnt_q - CW'(1);
        end
        D_THRESH: begin
          if (bus.abort) ab_q <= 1'b1;
          if (last) begin
            cnt_q     <= CW'(len_m1_q);
            st_q      <= D_READ;
            setting_q <= 7'd3;
          end else cnt_q <= cnt_q - CW'(1);
        end
        D_READ: begin
          if (bus.abort) ab_q <= 1'b1;
          if (last) begin
            st_q      <= D_RET;
            setting_q <= 7'd0;
          end else cnt_q <= cnt_q - CW'(1);
        end
        default: begin
          st_q      <= D_IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          aborted_q <= ab_q;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_cfg_driver.sv
// tb_neuron_cfg_driver: table-driven directed vectors for the configuration sequencer
module tb_neuron_cfg_driver;
  typedef struct {
    logic        rst_n, start, abort, spike;
    logic [7:0]  rl;
    logic [6:0]  set;
    logic [1:0]  peer;
    logic [7:0]  cfg;
    logic        busy, done, abd;
    logic [15:0] cnt;
  } row_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  row_t q[$];
  neuron_cfg_driver_if bus();
  neuron_cfg_driver dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic void add(logic r, logic st, logic ab, logic sp, logic [7:0] rl, logic [6:0] set,
                              logic [1:0] peer, logic [7:0] cfg, logic busy, logic done, logic abd,
                              logic [15:0] cnt);
    row_t x;
    x.rst_n = r; x.start = st; x.abort = ab; x.spike = sp; x.rl = rl;
    x.set = set; x.peer = peer; x.cfg = cfg; x.busy = busy; x.done = done; x.abd = abd; x.cnt = cnt;
    q.push_back(x);
  endfunction
  // rows for cycles cf..ct of an undisturbed run started at cycle 0 (HOLD=4, effective READ length r)
  function automatic void gen_run(logic [7:0] rl, int r, logic sp, int prev, int cf, int ct);
    for (int c = cf; c <= ct; c++) begin
      logic [6:0] set;
      logic [1:0] peer;
      logic [7:0] cfg;
      int cnt;
      set  = (c >= 1 && c <= 4) ? 7'd1 : (c >= 5 && c <= 8) ? 7'd2 : (c >= 9 && c <= 8 + r) ? 7'd3 : 7'd0;
      peer = (c >= 2 && c <= 5) ? 2'd1 : (c >= 6 && c <= 9) ? 2'd2 : (c >= 10 && c <= 9 + r) ? 2'd3 : 2'd0;
      cfg  = (peer == 2'd1) ? 8'h3C : (peer == 2'd2) ? 8'h50 : 8'h00;
      cnt  = (c == 0) ? prev : (sp && c >= 11) ? ((c - 10 < r) ? c - 10 : r) : 0;
      add(1'b1, c == 0, 1'b0, sp, rl, set, peer, cfg, c >= 1 && c <= 9 + r, c == 10 + r, 1'b0, 16'(cnt));
    end
  endfunction
  task automatic check(string name, int idx, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL row %0d %s: got %0h expected %0h", idx, name, act, exp);
    end
  endtask
  initial begin
    int b;
    bus.start = 1'b0; bus.abort = 1'b0; bus.spike_in = 1'b0;
    bus.beta_in = 8'h3C; bus.thresh_in = 8'h50; bus.read_len = 8'd5;
    // reset state, then idle with abort asserted (must be ignored)
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 7'd0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 7'd0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 7'd0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    // nominal run, spike_in=0, with abort alongside the accepted start
    b = q.size();
    gen_run(8'd5, 5, 1'b0, 0, 0, 15);
    q[b].abort = 1'b1;
    // nominal run with spike_in=1
    gen_run(8'd5, 5, 1'b1, 0, 0, 15);
    // read_len=0 behaves as 1
    gen_run(8'd0, 1, 1'b1, 5, 0, 11);
    // abort pulse in D_BETA at cycle 2
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'd5, 7'd0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 7'd1, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 7'd1, 2'd1, 8'h3C, 1'b1, 1'b0, 1'b0, 16'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 7'd2, 2'd1, 8'h3C, 1'b1, 1'b0, 1'b0, 16'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 7'd3, 2'd2, 8'h50, 1'b1, 1'b0, 1'b0, 16'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 7'd0, 2'd3, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 7'd0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, 16'd0);
    // starts while busy ignored; start in the done cycle launches a new run
    b = q.size();
    gen_run(8'd5, 5, 1'b1, 0, 0, 15);
    q[b + 3].start = 1'b1;
    q[b + 10].start = 1'b1;
    q[b + 15].start = 1'b1;
    gen_run(8'd5, 5, 1'b1, 5, 1, 15);
    // reset mid-run at cycle 7, then a fresh nominal run
    b = q.size();
    gen_run(8'd5, 5, 1'b0, 5, 0, 7);
    q[b + 7].rst_n = 1'b0;
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 7'd0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0);
    gen_run(8'd5, 5, 1'b0, 0, 0, 15);
    repeat (2) @(posedge clk);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      check("setting", i, 16'(bus.setting), 16'(q[i].set));
      check("peer_state", i, 16'(bus.peer_state), 16'(q[i].peer));
      check("cfg_data", i, 16'(bus.cfg_data), 16'(q[i].cfg));
      check("busy", i, 16'(bus.busy), 16'(q[i].busy));
      check("done", i, 16'(bus.done), 16'(q[i].done));
      check("spike_count", i, bus.spike_count, q[i].cnt);
      if (q[i].done) check("aborted", i, 16'(bus.aborted), 16'(q[i].abd));
      rst_n        = q[i].rst_n;
      bus.start    = q[i].start;
      bus.abort    = q[i].abort;
      bus.spike_in = q[i].spike;
      bus.read_len = q[i].rl;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
